// File: rtl/stepped_pair_counter_bank_pkg.sv
// rtl/stepped_pair_counter_bank_pkg.sv - op encodings, channel state and width helpers
package stepped_pair_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    // Channel state is a pure function of the step count k
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } ch_state_t;

    // Channel select width; a single channel still gets a one-bit select
    function automatic int chw_of(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Step count width, wide enough to hold max_steps itself
    function automatic int kw_of(input int max_steps);
        return $clog2(max_steps + 1);
    endfunction

endpackage

// File: rtl/stepped_pair_counter_bank_if.sv
// rtl/stepped_pair_counter_bank_if.sv - command and observation bundle of the counter bank
interface stepped_pair_counter_bank_if #(
    parameter int W         = 16,
    parameter int NCH       = 4,
    parameter int MAX_STEPS = 1000
);
    import stepped_pair_pkg::*;

    localparam int CHW = chw_of(NCH);
    localparam int KW  = kw_of(MAX_STEPS);

    logic               step_all;
    logic               cmd_valid;
    logic [CHW-1:0]     cmd_ch;
    logic [1:0]         cmd_op;
    logic [NCH*W-1:0]   x_out;
    logic [NCH*W-1:0]   y_out;
    logic [NCH*KW-1:0]  k_out;
    logic [NCH-1:0]     full;
    logic               uflow;
    logic               wrapped;
    logic               bad_ch;
    logic               inv_err;
    logic               forbid_hit;

    modport master (
        output step_all, cmd_valid, cmd_ch, cmd_op,
        input  x_out, y_out, k_out, full, uflow, wrapped, bad_ch, inv_err, forbid_hit
    );

    modport slave (
        input  step_all, cmd_valid, cmd_ch, cmd_op,
        output x_out, y_out, k_out, full, uflow, wrapped, bad_ch, inv_err, forbid_hit
    );

endinterface

// File: rtl/stepped_pair_counter_bank_channel.sv
// rtl/stepped_pair_counter_bank_channel.sv - one (x, y, k) counter pair driven by a resolved op
module stepped_pair_channel
    import stepped_pair_pkg::*;
#(
    parameter int W         = 16,
    parameter int KW        = 10,
    parameter int X_INIT    = 2,
    parameter int Y_INIT    = 0,
    parameter int STEP_X    = 2,
    parameter int STEP_Y    = 1,
    parameter int MAX_STEPS = 1000,
    parameter int WRAP      = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      op,
    output logic [W-1:0]    x,
    output logic [W-1:0]    y,
    output logic [KW-1:0]   k,
    output ch_state_t       state,
    output logic            uflow,
    output logic            wrapped
);

    localparam logic [W-1:0]  XI   = W'(X_INIT);
    localparam logic [W-1:0]  YI   = W'(Y_INIT);
    localparam logic [W-1:0]  SX   = W'(STEP_X);
    localparam logic [W-1:0]  SY   = W'(STEP_Y);
    localparam logic [KW-1:0] KMAX = KW'(MAX_STEPS);

    logic [W-1:0]  x_q, y_q, x_d, y_d;
    logic [KW-1:0] k_q, k_d;
    logic          uflow_q, uflow_d, wrap_q, wrap_d;

    // Classify the registered step count into idle / running / full
    always_comb begin
        if (k_q == '0)
            state = IDLE;
        else if (k_q == KMAX)
            state = FULL;
        else
            state = RUN;
    end

    // Next pair and one-cycle event flags for the op chosen this cycle
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        uflow_d = 1'b0;
        wrap_d  = 1'b0;
        unique case (op)
            OP_UP: begin
                if (state != FULL) begin
                    x_d = x_q + SX;
                    y_d = y_q + SY;
                    k_d = k_q + 1'b1;
                end else if (WRAP != 0) begin
                    x_d    = XI;
                    y_d    = YI;
                    k_d    = '0;
                    wrap_d = 1'b1;
                end
            end
            OP_DOWN: begin
                if (state != IDLE) begin
                    x_d = x_q - SX;
                    y_d = y_q - SY;
                    k_d = k_q - 1'b1;
                end else begin
                    uflow_d = 1'b1;
                end
            end
            OP_CLR: begin
                x_d = XI;
                y_d = YI;
                k_d = '0;
            end
            default: ;
        endcase
    end

    // Register the pair, the step count and the event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= XI;
            y_q     <= YI;
            k_q     <= '0;
            uflow_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            uflow_q <= uflow_d;
            wrap_q  <= wrap_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign k       = k_q;
    assign uflow   = uflow_q;
    assign wrapped = wrap_q;

endmodule

// File: rtl/stepped_pair_counter_bank.sv
// rtl/stepped_pair_counter_bank.sv - bank of lockstep (x, y) counters with trajectory monitors
module stepped_pair_counter_bank
    import stepped_pair_pkg::*;
#(
    parameter int W         = 16,
    parameter int NCH       = 4,
    parameter int X_INIT    = 2,
    parameter int Y_INIT    = 0,
    parameter int STEP_X    = 2,
    parameter int STEP_Y    = 1,
    parameter int MAX_STEPS = 1000,
    parameter int WRAP      = 0,
    parameter int FORB_X    = 4,
    parameter int FORB_Y    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    stepped_pair_counter_bank_if.slave bus
);

    localparam int CHW = chw_of(NCH);
    localparam int KW  = kw_of(MAX_STEPS);

    localparam logic [W-1:0] XI = W'(X_INIT);
    localparam logic [W-1:0] YI = W'(Y_INIT);
    localparam logic [W-1:0] SX = W'(STEP_X);
    localparam logic [W-1:0] SY = W'(STEP_Y);
    localparam logic [W-1:0] FX = W'(FORB_X);
    localparam logic [W-1:0] FY = W'(FORB_Y);

    logic [1:0]    ops      [NCH];
    logic [W-1:0]  xs       [NCH];
    logic [W-1:0]  ys       [NCH];
    logic [KW-1:0] ks       [NCH];
    ch_state_t     states   [NCH];
    logic [NCH-1:0] uflow_v, wrap_v;

    logic               bad_now, bad_q;
    logic               inv_now, inv_q;
    logic               forb_now, forb_q;
    logic [NCH*W-1:0]   x_all, y_all;
    logic [NCH*KW-1:0]  k_all;
    logic [NCH-1:0]     full_all;

    // A command aimed past the last channel is flagged and dropped
    always_comb begin
        bad_now = bus.cmd_valid && (int'(bus.cmd_ch) >= NCH);
    end

    // Per-channel op: a targeted non-hold command beats the broadcast step
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ops[i] = bus.step_all ? OP_UP : OP_HOLD;
            if (bus.cmd_valid && !bad_now && bus.cmd_ch == CHW'(i) && bus.cmd_op != OP_HOLD)
                ops[i] = bus.cmd_op;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        stepped_pair_channel #(
            .W(W), .KW(KW), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
            .STEP_X(STEP_X), .STEP_Y(STEP_Y), .MAX_STEPS(MAX_STEPS), .WRAP(WRAP)
        ) u_ch (
            .clk(clk), .rst(rst), .op(ops[g]),
            .x(xs[g]), .y(ys[g]), .k(ks[g]), .state(states[g]),
            .uflow(uflow_v[g]), .wrapped(wrap_v[g])
        );
    end

    // Pack channel state onto the flat buses, channel 0 in the LSBs
    always_comb begin
        x_all    = '0;
        y_all    = '0;
        k_all    = '0;
        full_all = '0;
        for (int i = 0; i < NCH; i++) begin
            x_all[i*W +: W]   = xs[i];
            y_all[i*W +: W]   = ys[i];
            k_all[i*KW +: KW] = ks[i];
            full_all[i]       = (states[i] == FULL);
        end
    end

    // Monitors: recompute the trajectory from k with a multiply, and spot the forbidden pair
    always_comb begin
        inv_now  = 1'b0;
        forb_now = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (xs[i] != XI + SX * W'(ks[i]) || ys[i] != YI + SY * W'(ks[i]))
                inv_now = 1'b1;
            if (xs[i] == FX && ys[i] == FY)
                forb_now = 1'b1;
        end
    end

    // bad_ch pulse plus the two sticky monitor flags
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_q  <= 1'b0;
            inv_q  <= 1'b0;
            forb_q <= 1'b0;
        end else begin
            bad_q  <= bad_now;
            inv_q  <= inv_q | inv_now;
            forb_q <= forb_q | forb_now;
        end
    end

    assign bus.x_out      = x_all;
    assign bus.y_out      = y_all;
    assign bus.k_out      = k_all;
    assign bus.full       = full_all;
    assign bus.uflow      = |uflow_v;
    assign bus.wrapped    = |wrap_v;
    assign bus.bad_ch     = bad_q;
    assign bus.inv_err    = inv_q;
    assign bus.forbid_hit = forb_q;

endmodule

// File: tb/tb_stepped_pair_counter_bank.sv
// tb/tb_stepped_pair_counter_bank.sv - randomized bench for three bank configurations against a step-count model
module tb_stepped_pair_counter_bank;
    import stepped_pair_pkg::*;

    localparam int XI = 2, YI = 0, SX = 2, SY = 1;

    // Configs: 0 default, 1 three channels/max 2/saturate/forbid (6,2), 2 max 2/wrap
    int cfg_nch  [3] = '{4, 3, 4};
    int cfg_max  [3] = '{1000, 2, 2};
    int cfg_wrap [3] = '{0, 0, 1};
    int cfg_fx   [3] = '{4, 6, 4};
    int cfg_fy   [3] = '{0, 2, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stepped_pair_counter_bank_if #(.W(16), .NCH(4), .MAX_STEPS(1000)) if_a ();
    stepped_pair_counter_bank_if #(.W(16), .NCH(3), .MAX_STEPS(2))    if_b ();
    stepped_pair_counter_bank_if #(.W(16), .NCH(4), .MAX_STEPS(2))    if_c ();

    stepped_pair_counter_bank #(.NCH(4), .MAX_STEPS(1000), .WRAP(0))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    stepped_pair_counter_bank #(.NCH(3), .MAX_STEPS(2), .WRAP(0), .FORB_X(6), .FORB_Y(2))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    stepped_pair_counter_bank #(.NCH(4), .MAX_STEPS(2), .WRAP(1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: only the step count per channel; x and y follow from it
    int km    [3][4];
    bit e_uf  [3];
    bit e_wr  [3];
    bit e_bad [3];
    bit e_forb[3];

    logic [15:0] obs_x [3][4];
    logic [15:0] obs_y [3][4];
    logic [31:0] obs_k [3][4];
    logic        obs_full [3][4];
    logic [4:0]  obs_f [3];

    always_comb begin
        obs_x    = '{default: '0};
        obs_y    = '{default: '0};
        obs_k    = '{default: '0};
        obs_full = '{default: 1'b0};
        for (int i = 0; i < 4; i++) begin
            obs_x[0][i]    = if_a.x_out[i*16 +: 16];
            obs_y[0][i]    = if_a.y_out[i*16 +: 16];
            obs_k[0][i]    = 32'(if_a.k_out[i*10 +: 10]);
            obs_full[0][i] = if_a.full[i];
            obs_x[2][i]    = if_c.x_out[i*16 +: 16];
            obs_y[2][i]    = if_c.y_out[i*16 +: 16];
            obs_k[2][i]    = 32'(if_c.k_out[i*2 +: 2]);
            obs_full[2][i] = if_c.full[i];
        end
        for (int i = 0; i < 3; i++) begin
            obs_x[1][i]    = if_b.x_out[i*16 +: 16];
            obs_y[1][i]    = if_b.y_out[i*16 +: 16];
            obs_k[1][i]    = 32'(if_b.k_out[i*2 +: 2]);
            obs_full[1][i] = if_b.full[i];
        end
        obs_f[0] = {if_a.uflow, if_a.wrapped, if_a.bad_ch, if_a.inv_err, if_a.forbid_hit};
        obs_f[1] = {if_b.uflow, if_b.wrapped, if_b.bad_ch, if_b.inv_err, if_b.forbid_hit};
        obs_f[2] = {if_c.uflow, if_c.wrapped, if_c.bad_ch, if_c.inv_err, if_c.forbid_hit};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int xv(input int k);
        return (XI + SX * k) & 32'hFFFF;
    endfunction

    function automatic int yv(input int k);
        return (YI + SY * k) & 32'hFFFF;
    endfunction

    task automatic model_update(input bit r, input bit sa, input bit cv, input int ch, input int op);
        for (int d = 0; d < 3; d++) begin
            e_uf[d]  = 1'b0;
            e_wr[d]  = 1'b0;
            e_bad[d] = 1'b0;
            if (r) begin
                for (int i = 0; i < 4; i++) km[d][i] = 0;
                e_forb[d] = 1'b0;
            end else begin
                for (int i = 0; i < cfg_nch[d]; i++)
                    if (xv(km[d][i]) == cfg_fx[d] && yv(km[d][i]) == cfg_fy[d]) e_forb[d] = 1'b1;
                e_bad[d] = cv && (ch >= cfg_nch[d]);
                for (int i = 0; i < cfg_nch[d]; i++) begin
                    int o;
                    o = (cv && ch == i && op != 0) ? op : (sa ? 1 : 0);
                    if (o == 1) begin
                        if (km[d][i] < cfg_max[d]) km[d][i]++;
                        else if (cfg_wrap[d] != 0) begin km[d][i] = 0; e_wr[d] = 1'b1; end
                    end else if (o == 2) begin
                        if (km[d][i] > 0) km[d][i]--;
                        else e_uf[d] = 1'b1;
                    end else if (o == 3) begin
                        km[d][i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic verify();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < cfg_nch[d]; i++) begin
                check($sformatf("cfg%0d.x%0d", d, i), obs_x[d][i], xv(km[d][i]));
                check($sformatf("cfg%0d.y%0d", d, i), obs_y[d][i], yv(km[d][i]));
                check($sformatf("cfg%0d.k%0d", d, i), obs_k[d][i], km[d][i]);
                check($sformatf("cfg%0d.full%0d", d, i), obs_full[d][i], km[d][i] == cfg_max[d]);
            end
            check($sformatf("cfg%0d.uflow", d),      obs_f[d][4], e_uf[d]);
            check($sformatf("cfg%0d.wrapped", d),    obs_f[d][3], e_wr[d]);
            check($sformatf("cfg%0d.bad_ch", d),     obs_f[d][2], e_bad[d]);
            check($sformatf("cfg%0d.inv_err", d),    obs_f[d][1], 1'b0);
            check($sformatf("cfg%0d.forbid_hit", d), obs_f[d][0], e_forb[d]);
        end
    endtask

    task automatic cycle(input bit r, input bit sa, input bit cv, input int ch, input int op);
        rst = r;
        if_a.step_all = sa; if_a.cmd_valid = cv; if_a.cmd_ch = 2'(ch); if_a.cmd_op = 2'(op);
        if_b.step_all = sa; if_b.cmd_valid = cv; if_b.cmd_ch = 2'(ch); if_b.cmd_op = 2'(op);
        if_c.step_all = sa; if_c.cmd_valid = cv; if_c.cmd_ch = 2'(ch); if_c.cmd_op = 2'(op);
        @(posedge clk);
        model_update(r, sa, cv, ch, op);
        #1;
        verify();
    endtask

    initial begin
        if_a.step_all = 0; if_a.cmd_valid = 0; if_a.cmd_ch = 0; if_a.cmd_op = 0;
        if_b.step_all = 0; if_b.cmd_valid = 0; if_b.cmd_ch = 0; if_b.cmd_op = 0;
        if_c.step_all = 0; if_c.cmd_valid = 0; if_c.cmd_ch = 0; if_c.cmd_op = 0;
        for (int d = 0; d < 3; d++) begin
            e_forb[d] = 1'b0;
            for (int i = 0; i < 4; i++) km[d][i] = 0;
        end

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        // broadcast steps from reset
        repeat (3) cycle(0, 1, 0, 0, 0);
        // three ups on ch1: saturate in cfg1, wrap in cfg2
        cycle(1, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 1, 1, 1);
        // three ups on ch0
        cycle(1, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 1, 0, 1);
        // underflow on ch2, then up and down
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 2, 2);
        cycle(0, 0, 1, 2, 1);
        cycle(0, 0, 1, 2, 2);
        // clear on ch3 beats step_all
        cycle(1, 0, 0, 0, 0);
        repeat (5) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 3, 3);
        // reach (6,2) on ch0, then idle to watch forbid_hit stick
        cycle(1, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 1, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 0);
        // channel 3 is out of range only for the three-channel config
        cycle(0, 0, 1, 3, 1);
        cycle(0, 1, 1, 3, 2);
        cycle(0, 0, 1, 3, 2);
        // reset wins over simultaneous commands
        cycle(1, 1, 1, 0, 1);
        // saturate the default config at 1000
        repeat (1003) cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 2, 2);
        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
